// File: rtl/rlc_sram_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------------------+
// | rlc_sram_arbiter: round-robin sharing of one read-only coefficient SRAM by two RLC decoders |
// | Revision 1.0                                                                         |
// +--------------------------------------------------------------------------------------+
module rlc_sram_arbiter #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 16,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cfg_we,
   input  logic              cfg_sel,
   input  logic [ADDR_W-1:0] cfg_base,
   input  logic [ADDR_W-1:0] cfg_len,
   input  logic              req0,
   input  logic              req1,
   output logic [DATA_W-1:0] din0,
   output logic [DATA_W-1:0] din1,
   output logic              valid0,
   output logic              valid1,
   output logic              exhausted0,
   output logic              exhausted1,
   output logic              mem_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, DELIVER = 2'd2} state_t;

   localparam logic [1:0] LAT = 2'(RD_LAT);

   state_t            state, state_nx;
   logic              grant, grant_nx;
   logic              last, last_nx;
   logic              pick;
   logic              cfg_ok;
   logic              mem_en_nx;
   logic [1:0]        mask, mask_nx;
   logic [1:0]        cnt, cnt_nx;
   logic [1:0]        exh, exh_nx;
   logic [1:0]        elig;
   logic [ADDR_W-1:0] mem_addr_nx;
   logic [ADDR_W-1:0] base [2];
   logic [ADDR_W-1:0] len [2];
   logic [ADDR_W-1:0] ptr [2];
   logic [ADDR_W-1:0] base_nx [2];
   logic [ADDR_W-1:0] len_nx [2];
   logic [ADDR_W-1:0] ptr_nx [2];
   logic [DATA_W-1:0] dout [2];
   logic [DATA_W-1:0] dout_nx [2];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         grant    <= 1'b0;
         last     <= 1'b1;
         mask     <= 2'b00;
         cnt      <= 2'd0;
         exh      <= 2'b11;
         mem_en   <= 1'b0;
         mem_addr <= '0;
         base     <= '{default: '0};
         len      <= '{default: '0};
         ptr      <= '{default: '0};
         dout     <= '{default: '0};
      end else begin
         state    <= state_nx;
         grant    <= grant_nx;
         last     <= last_nx;
         mask     <= mask_nx;
         cnt      <= cnt_nx;
         exh      <= exh_nx;
         mem_en   <= mem_en_nx;
         mem_addr <= mem_addr_nx;
         base     <= base_nx;
         len      <= len_nx;
         ptr      <= ptr_nx;
         dout     <= dout_nx;
      end
   end

   always_comb begin
      state_nx    = state;
      grant_nx    = grant;
      last_nx     = last;
      mask_nx     = 2'b00;
      cnt_nx      = cnt;
      mem_en_nx   = 1'b0;
      mem_addr_nx = mem_addr;
      base_nx     = base;
      len_nx      = len;
      ptr_nx      = ptr;
      dout_nx     = dout;

      // A write aimed at the requester whose read is in flight is discarded.
      cfg_ok = cfg_we && !((state != IDLE) && (cfg_sel == grant));
      if (cfg_ok) begin
         base_nx[cfg_sel] = cfg_base;
         len_nx[cfg_sel]  = cfg_len;
         ptr_nx[cfg_sel]  = '0;
      end

      elig = {req1, req0} & ~exh & ~mask;
      pick = (elig == 2'b11) ? ~last : elig[1];

      case (state)
         IDLE: begin
            if ((elig != 2'b00) && !(cfg_we && (cfg_sel == pick))) begin
               grant_nx     = pick;
               mem_en_nx    = 1'b1;
               mem_addr_nx  = base[pick] + ptr[pick];
               ptr_nx[pick] = ptr[pick] + ADDR_W'(1);
               cnt_nx       = 2'd0;
               state_nx     = READ;
            end
         end
         READ: begin
            if (cnt == LAT) begin
               dout_nx[grant] = mem_rdata;
               state_nx       = DELIVER;
            end else begin
               cnt_nx = cnt + 2'd1;
            end
         end
         DELIVER: begin
            last_nx        = grant;
            mask_nx[grant] = 1'b1;
            state_nx       = IDLE;
         end
         default: state_nx = IDLE;
      endcase

      exh_nx[0] = (ptr_nx[0] == len_nx[0]);
      exh_nx[1] = (ptr_nx[1] == len_nx[1]);
   end

   assign din0       = dout[0];
   assign din1       = dout[1];
   assign valid0     = (state == DELIVER) && !grant;
   assign valid1     = (state == DELIVER) && grant;
   assign exhausted0 = exh[0];
   assign exhausted1 = exh[1];
   assign busy       = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_rlc_sram_arbiter.sv
`default_nettype none
// tb_rlc_sram_arbiter: directed table, multi-cycle corner sequences and a randomized run
// against a cycle-accurate transaction model of the arbiter.
module tb_rlc_sram_arbiter;
   localparam int ADDR_W = 10;
   localparam int DATA_W = 16;
   localparam int RD_LAT = 1;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              cfg_we = 1'b0, cfg_sel = 1'b0;
   logic [ADDR_W-1:0] cfg_base = '0, cfg_len = '0;
   logic              req0 = 1'b0, req1 = 1'b0;
   logic [DATA_W-1:0] din0, din1, mem_rdata;
   logic              valid0, valid1, exhausted0, exhausted1, mem_en, busy;
   logic [ADDR_W-1:0] mem_addr;

   rlc_sram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
      .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
      .cfg_base(cfg_base), .cfg_len(cfg_len), .req0(req0), .req1(req1),
      .din0(din0), .din1(din1), .valid0(valid0), .valid1(valid1),
      .exhausted0(exhausted0), .exhausted1(exhausted1), .mem_en(mem_en),
      .mem_addr(mem_addr), .mem_rdata(mem_rdata), .busy(busy));

   always #5 clk = ~clk;

   // SRAM: data for the address presented appears RD_LAT edges later.
   logic [DATA_W-1:0] mem [1024];
   logic [DATA_W-1:0] pipe [RD_LAT];
   always @(posedge clk) begin
      pipe[0] <= mem[mem_addr];
      for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
   end
   assign mem_rdata = pipe[RD_LAT-1];

   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Transaction model: owner = requester with a read in flight (-1 when idle),
   // age = cycles since its grant decision; the word is delivered at age RD_LAT+2.
   int                m_owner, m_age, m_mask;
   bit                m_last;
   logic [ADDR_W-1:0] m_base [2], m_len [2], m_ptr [2];
   logic [ADDR_W-1:0] m_addr;
   logic [DATA_W-1:0] m_din [2];

   task automatic model_reset();
      m_owner = -1; m_age = 0; m_mask = -1; m_last = 1'b1; m_addr = '0;
      for (int i = 0; i < 2; i++) begin
         m_base[i] = '0; m_len[i] = '0; m_ptr[i] = '0; m_din[i] = '0;
      end
   endtask

   task automatic model_advance();
      bit blocked, e0, e1;
      int g, new_mask;
      blocked  = cfg_we && (m_owner != -1) && (m_owner == int'(cfg_sel));
      new_mask = -1;
      if (m_owner != -1) begin
         if (m_age == RD_LAT + 1) m_din[m_owner] = mem[m_addr];
         if (m_age == RD_LAT + 2) begin
            m_last = (m_owner == 1); new_mask = m_owner; m_owner = -1;
         end else begin
            m_age++;
         end
      end else begin
         e0 = req0 && (m_ptr[0] != m_len[0]) && (m_mask != 0);
         e1 = req1 && (m_ptr[1] != m_len[1]) && (m_mask != 1);
         if (e0 || e1) begin
            g = (e0 && e1) ? (m_last ? 0 : 1) : (e1 ? 1 : 0);
            if (!(cfg_we && int'(cfg_sel) == g)) begin
               m_addr   = m_base[g] + m_ptr[g];
               m_ptr[g] = m_ptr[g] + 10'd1;
               m_owner  = g;
               m_age    = 1;
            end
         end
      end
      if (cfg_we && !blocked) begin
         m_base[cfg_sel] = cfg_base; m_len[cfg_sel] = cfg_len; m_ptr[cfg_sel] = '0;
      end
      m_mask = new_mask;
   endtask

   function automatic logic [47:0] model_vec();
      logic bz, en, v0, v1;
      bz = (m_owner != -1);
      en = bz && (m_age == 1);
      v0 = (m_owner == 0) && (m_age == RD_LAT + 2);
      v1 = (m_owner == 1) && (m_age == RD_LAT + 2);
      return {v0, v1, en, bz, m_ptr[0] == m_len[0], m_ptr[1] == m_len[1],
              m_din[0], m_din[1], en ? m_addr : 10'd0};
   endfunction

   function automatic logic [47:0] actual_vec();
      return {valid0, valid1, mem_en, busy, exhausted0, exhausted1,
              din0, din1, mem_en ? mem_addr : 10'd0};
   endfunction

   localparam logic [47:0] RESET_VEC = {6'b000011, 42'd0};

   // Inputs are driven at the falling edge; the model advances over the same edge the DUT sees.
   task automatic step();
      model_advance();
      @(posedge clk);
      @(negedge clk);
      chk("model", 64'(actual_vec()), 64'(model_vec()));
   endtask

   task automatic do_reset();
      reset = 1'b0; cfg_we = 1'b0; cfg_sel = 1'b0; cfg_base = '0; cfg_len = '0;
      req0 = 1'b0; req1 = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic cfg(input logic sel, input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] l);
      cfg_we = 1'b1; cfg_sel = sel; cfg_base = b; cfg_len = l;
      step();
      cfg_we = 1'b0;
   endtask

   task automatic wait_en(output logic [ADDR_W-1:0] a, output logic hit);
      hit = 1'b0; a = '0;
      for (int i = 0; i < 20 && !hit; i++) begin
         step();
         if (mem_en) begin hit = 1'b1; a = mem_addr; end
      end
   endtask

   typedef struct {
      logic              we;
      logic [ADDR_W-1:0] base, len;
      logic              rq0;
      logic              v0, en;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] d0;
      logic              ex0;
   } vec_t;
   vec_t tbl [13];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      logic [ADDR_W-1:0] a;
      logic              hit;
      int                order [$];
      int                en_cyc [$];
      logic [ADDR_W-1:0] addrs [$];
      int                cyc, nv;
      logic [3:0]        ord_bits;
      logic [19:0]       seq;

      for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
      mem[10'h010] = 16'h20C0;
      mem[10'h011] = 16'h1000;

      // Outputs of the cycle after each row's inputs.
      tbl[0]  = '{1'b1, 10'h010, 10'd2, 1'b0, 1'b0, 1'b0, 10'h000, 16'h0000, 1'b0};
      tbl[1]  = '{1'b0, 10'h000, 10'd0, 1'b1, 1'b0, 1'b1, 10'h010, 16'h0000, 1'b0};
      tbl[2]  = '{1'b0, 10'h000, 10'd0, 1'b1, 1'b0, 1'b0, 10'h000, 16'h0000, 1'b0};
      tbl[3]  = '{1'b0, 10'h000, 10'd0, 1'b1, 1'b1, 1'b0, 10'h000, 16'h20C0, 1'b0};
      tbl[4]  = '{1'b0, 10'h000, 10'd0, 1'b1, 1'b0, 1'b0, 10'h000, 16'h20C0, 1'b0};
      tbl[5]  = '{1'b0, 10'h000, 10'd0, 1'b1, 1'b0, 1'b0, 10'h000, 16'h20C0, 1'b0};
      tbl[6]  = '{1'b0, 10'h000, 10'd0, 1'b1, 1'b0, 1'b1, 10'h011, 16'h20C0, 1'b1};
      tbl[7]  = '{1'b0, 10'h000, 10'd0, 1'b1, 1'b0, 1'b0, 10'h000, 16'h20C0, 1'b1};
      tbl[8]  = '{1'b0, 10'h000, 10'd0, 1'b1, 1'b1, 1'b0, 10'h000, 16'h1000, 1'b1};
      for (int i = 9; i < 13; i++)
         tbl[i] = '{1'b0, 10'h000, 10'd0, 1'b1, 1'b0, 1'b0, 10'h000, 16'h1000, 1'b1};

      // Reset values, then single requester with a held request.
      do_reset();
      chk("reset_state", 64'(actual_vec()), 64'(RESET_VEC));
      for (int i = 0; i < 13; i++) begin
         cfg_we = tbl[i].we; cfg_sel = 1'b0; cfg_base = tbl[i].base; cfg_len = tbl[i].len;
         req0 = tbl[i].rq0; req1 = 1'b0;
         step();
         chk("table", 64'({valid0, mem_en, mem_en ? mem_addr : 10'd0, din0, exhausted0}),
             64'({tbl[i].v0, tbl[i].en, tbl[i].addr, tbl[i].d0, tbl[i].ex0}));
      end

      // Tie: both requesting continuously.
      do_reset();
      cfg(1'b0, 10'h100, 10'd4);
      cfg(1'b1, 10'h200, 10'd4);
      req0 = 1'b1; req1 = 1'b1;
      for (cyc = 0; cyc < 40; cyc++) begin
         step();
         if (valid0) order.push_back(0);
         if (valid1) order.push_back(1);
         if (mem_en) en_cyc.push_back(cyc);
      end
      chk("tie_count", 64'(order.size()), 64'd8);
      ord_bits = 4'hF;
      for (int i = 0; i < 4 && i < order.size(); i++) ord_bits[3-i] = order[i][0];
      chk("tie_order", 64'(ord_bits), 64'(4'b0101));
      for (int i = 1; i < 4; i++)
         chk("tie_spacing", 64'((i < en_cyc.size()) ? en_cyc[i] - en_cyc[i-1] : -1),
             64'(RD_LAT + 3));

      // Address wrap.
      do_reset();
      cfg(1'b0, 10'h3FF, 10'd2);
      req0 = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step();
         if (mem_en) addrs.push_back(mem_addr);
      end
      chk("wrap_count", 64'(addrs.size()), 64'd2);
      seq = '1;
      for (int i = 0; i < 2 && i < addrs.size(); i++) seq[19-10*i -: 10] = addrs[i];
      chk("wrap_seq", 64'(seq), 64'({10'h3FF, 10'h000}));

      // Config collision: dropped during READ, honoured in IDLE.
      do_reset();
      cfg(1'b0, 10'h040, 10'd8);
      req0 = 1'b1;
      wait_en(a, hit);
      chk("coll_first", 64'({hit, a}), 64'({1'b1, 10'h040}));
      cfg(1'b0, 10'h080, 10'd8);
      wait_en(a, hit);
      chk("coll_dropped", 64'({hit, a}), 64'({1'b1, 10'h041}));
      hit = 1'b0;
      for (int i = 0; i < 20 && !hit; i++) begin
         step();
         hit = valid0;
      end
      chk("coll_valid", 64'(hit), 64'd1);
      step();
      cfg(1'b0, 10'h080, 10'd8);
      wait_en(a, hit);
      chk("coll_idle_write", 64'({hit, a}), 64'({1'b1, 10'h080}));

      // Reset during READ.
      do_reset();
      cfg(1'b0, 10'h020, 10'd4);
      req0 = 1'b1;
      wait_en(a, hit);
      chk("rst_read_en", 64'({hit, a}), 64'({1'b1, 10'h020}));
      #2 reset = 1'b0;
      #1 chk("rst_async", 64'(actual_vec()), 64'(RESET_VEC));
      model_reset();
      @(negedge clk);
      reset = 1'b1;
      nv = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         nv += int'(valid0) + int'(valid1);
      end
      chk("rst_no_valid", 64'(nv), 64'd0);

      // Randomized traffic with occasional reconfiguration.
      do_reset();
      cfg(1'b0, 10'($urandom), 10'd40);
      cfg(1'b1, 10'($urandom), 10'd40);
      for (int i = 0; i < 800; i++) begin
         req0     = ($urandom % 10) < 7;
         req1     = ($urandom % 10) < 7;
         cfg_we   = ($urandom % 12) == 0;
         cfg_sel  = 1'($urandom);
         cfg_base = 10'($urandom);
         cfg_len  = 10'($urandom % 7);
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/rlc_sram_arbiter.md
# rlc_sram_arbiter

Shares one single-port, read-only coefficient SRAM between two `rlc_decoder` instances. Each decoder raises its `sram_req` level when it needs the next 16-bit packed RLC word. The arbiter picks a requester round-robin, reads the next word from that requester's configured buffer and returns it on that requester's `sram_din`/`sram_valid` pair. Buffer base address and word count for each requester are programmed through a simple config write port.

## Interface
- `ADDR_W`, 10: SRAM word-address width.
- `DATA_W`, 16: SRAM word width; matches the decoder `sram_din`.
- `RD_LAT`, 1: SRAM read latency in cycles. Legal range is 1..3.

- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserted at 0).
- `cfg_we`  in  1  config write strobe, one cycle.
- `cfg_sel`  in  1  requester index being configured.
- `cfg_base`  in  ADDR_W  first word address of the buffer.
- `cfg_len`  in  ADDR_W  number of words in the buffer.
- `req0`, `req1`  in  1  decoder `sram_req` levels.
- `din0`, `din1`  out  DATA_W  word returned to each decoder.
- `valid0`, `valid1`  out  1  one-cycle data strobe to each decoder.
- `exhausted0`, `exhausted1`  out  1  high when the requester's read pointer equals its length.
- `mem_en`  out  1  SRAM read enable.
- `mem_addr`  out  ADDR_W  SRAM read address.
- `mem_rdata`  in  DATA_W  SRAM read data.
- `busy`  out  1  high when the FSM is not in IDLE.

## Operation
- Per-requester state: `base`, `len`, `ptr` (all ADDR_W wide), plus a 1-bit `last` pointer for round-robin. The `exhaustedX` outputs are registered and equal `ptr==len`.
- A requester is eligible when all of the following hold:
  - its `reqX` is 1;
  - `exhaustedX` is 0;
  - it was not served in the immediately preceding DELIVER. The decoder drops `req` one cycle after `valid`, so this one-cycle mask prevents double-issue.
- FSM states and transitions:
  - IDLE: if no requester is eligible, stay in IDLE. If exactly one is eligible, grant it. If both are eligible, grant `!last`. On a grant, register `grant`, drive `mem_en=1` and `mem_addr=base[g]+ptr[g]` (modulo 2^ADDR_W, wraps silently), increment `ptr[g]`, then go to READ.
  - READ: `mem_en` returns to 0. Count RD_LAT cycles, then capture `mem_rdata` into `din[g]` and go to DELIVER.
  - DELIVER: `valid[g]=1` for exactly one cycle, `last<=g`, set the mask for `g`, then go to IDLE. `din[g]` holds its value until the next delivery to `g`.
- Config write: when `cfg_we` is 1 at an edge, load `base[cfg_sel]` and `len[cfg_sel]`, and clear `ptr[cfg_sel]`.
  - If `cfg_sel` equals an in-flight `grant` (FSM in READ or DELIVER), the write is dropped entirely.
  - Writing `cfg_len=0` makes `exhaustedX` read 1 on the next cycle.
- A `reqX` that arrives while `exhaustedX` is 1 is ignored indefinitely. No error is signalled; the decoder stalls.
- Only one read is ever outstanding, because the SRAM has a single port.

## Timing
- Reset values: all outputs 0, except `exhausted0` and `exhausted1`, which are 1 because `len` and `ptr` both reset to 0. On reset, the FSM goes to IDLE and `last` goes to 1, so requester 0 wins the first tie.
- Reset asserted mid-operation: state clears immediately and asynchronously. The in-flight read is discarded and no `valid` pulse is produced.
- Latency: with `reqX` first eligible in cycle T:
  - `mem_en` is high in cycle T+1;
  - `mem_rdata` is sampled at the end of cycle T+RD_LAT+1;
  - `validX` is high in cycle T+RD_LAT+2.
  - For RD_LAT=1, `valid` arrives 3 cycles after `req`.
- Throughput: one word every RD_LAT+3 cycles when both decoders are requesting continuously, alternating 0,1,0,1.
- Simultaneous `cfg_we` and a grant to the same requester in IDLE: the config write wins. The grant is suppressed for that cycle and is re-evaluated the next cycle with the new `ptr=0`.
- `valid0` and `valid1` are never high in the same cycle. `mem_en` is never high on two consecutive cycles.

## Test plan
- Single requester: configure requester 0 with base=0x010, len=2 (SRAM holds 0x20C0 at 0x010 and 0x1000 at 0x011), hold `req0`. Required: `valid0` pulses carrying 0x20C0 then 0x1000, each RD_LAT+2 cycles after the eligible `req`. `exhausted0` rises after the second issue, and a third `req0` gets no response.
- Tie: configure both requesters with len=4 and assert `req0` and `req1` together right after reset. Required: deliveries in order 0,1,0,1, with `mem_en` pulses spaced RD_LAT+3 cycles apart.
- Held request: `req0` stays high through the cycle after `valid0`. Required: exactly one word per DELIVER, and the next `mem_en` no earlier than 2 cycles after `valid0`.
- Address wrap: ADDR_W=10, base=0x3FF, len=2. Required: `mem_addr` sequence 0x3FF then 0x000.
- Config collision: issue `cfg_we` with `cfg_sel=0` while requester 0 is in READ. Required: the write is dropped and the next address continues the old sequence. The same write issued in IDLE resets `ptr` to 0.
- Reset mid-READ: pull `reset` to 0 during the READ cycle. Required: all outputs go to their reset values immediately, and no `valid` pulse appears after reset is released.
